alu_logical_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_logical_stage.sv | 36 +++
 rtl/alu_logical_pipe.sv | 80 ++++++++
 tb/tb_alu_logical_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the logical ALU pipeline.
// Op encodings and op-field width.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_LOG_AND  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_OR   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_XOR  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_NOR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_ANDN = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_XNOR = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_PASS = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_LOG_NOT  = 3'b111;

endpackage

// File: rtl/alu_logical_stage.sv
// One elastic register slice: valid bit plus payload.
// Loads whenever empty or when downstream drains it.
module alu_logical_stage #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready_dn,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready_dn;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Capture upstream slot when this slot is free or draining
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/alu_logical_pipe.sv
// Pipelined bitwise logic unit with zero/parity flags.
// Elastic valid/ready chain of STAGES register slices.
module alu_logical_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in1,
  input  logic [WIDTH-1:0]    in2,
  input  logic [ALU_OP_W-1:0] op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic                zero,
  output logic                parity
);

  localparam int P = WIDTH + 2;

  // Payload layout: {result, zero, parity}
  function automatic logic [P-1:0] f_eval(
    input logic [WIDTH-1:0]    a,
    input logic [WIDTH-1:0]    b,
    input logic [ALU_OP_W-1:0] o
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (o)
      ALU_LOG_AND:  r = a & b;
      ALU_LOG_OR:   r = a | b;
      ALU_LOG_XOR:  r = a ^ b;
      ALU_LOG_NOR:  r = ~(a | b);
      ALU_LOG_ANDN: r = a & ~b;
      ALU_LOG_XNOR: r = ~(a ^ b);
      ALU_LOG_PASS: r = a;
      ALU_LOG_NOT:  r = ~a;
      default:      r = '0;
    endcase
    return {r, ~|r, ^r};
  endfunction

  logic         w_v   [STAGES+1];
  logic [P-1:0] w_d   [STAGES+1];
  logic         w_rdy [STAGES+1];

  // Input-side payload computed before stage 0
  always_comb begin
    w_v[0] = in_valid;
    w_d[0] = f_eval(in1, in2, op);
  end

  assign w_rdy[STAGES] = out_ready;
  assign in_ready      = w_rdy[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    alu_logical_stage #(
      .W (P)
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_valid    (w_v[g]),
      .i_data     (w_d[g]),
      .i_ready_dn (w_rdy[g+1]),
      .o_ready    (w_rdy[g]),
      .o_valid    (w_v[g+1]),
      .o_data     (w_d[g+1])
    );
  end

  assign out_valid = w_v[STAGES];
  assign out       = w_d[STAGES][P-1:2];
  assign zero      = w_d[STAGES][1];
  assign parity    = w_d[STAGES][0];

endmodule

// File: tb/tb_alu_logical_pipe.sv
// Self-checking bench for alu_logical_pipe.
// Scoreboard queue plus directed checks.
module tb_alu_logical_pipe;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero;
  logic         parity;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;

  logic [W+1:0] q[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  alu_logical_pipe #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [2:0]   o
  );
    logic [W-1:0] r;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: r = a & ~b;
      3'd5: r = ~(a ^ b);
      3'd6: r = a;
      default: r = ~a;
    endcase
    return {r, (r == '0), ^r};
  endfunction

  logic         prev_stall = 1'b0;
  logic [W+1:0] prev_out;
  logic [W+1:0] exp_v;
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("stall_stable", {out, zero, parity}, prev_out);
      end
      if (out_valid && out_ready) begin
        chk("pop_nonempty", (q.size() > 0), 1'b1);
        if (q.size() > 0) begin
          exp_v = q.pop_front();
          chk("scoreboard", {out, zero, parity}, exp_v);
        end
        n_pop++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in1, in2, op));
        n_push++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out, zero, parity};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sweep_exp [8];
  logic [W-1:0] held;
  int           acc;
  int           cyc;

  initial begin
    sweep_exp[0] = 32'h0000_0005;
    sweep_exp[1] = 32'h0000_00AF;
    sweep_exp[2] = 32'h0000_00AA;
    sweep_exp[3] = 32'hFFFF_FF50;
    sweep_exp[4] = 32'h0000_00A0;
    sweep_exp[5] = 32'hFFFF_FF55;
    sweep_exp[6] = 32'h0000_00A5;
    sweep_exp[7] = 32'hFFFF_FF5A;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    op        = 3'd0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", out, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_parity", parity, 1'b0);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    in_valid = 1'b1;
    in1 = 32'hF0F0_F0F0;
    in2 = 32'hFF00_FF00;
    op  = 3'd0;
    step();
    in_valid = 1'b0;
    chk("lat_early", out_valid, 1'b0);
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("and_out", out, 32'hF000_F000);
    chk("and_zero", zero, 1'b0);
    chk("and_parity", parity, 1'b0);
    step();

    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        in_valid = 1'b1;
        in1 = 32'h0000_00A5;
        in2 = 32'h0000_000F;
        op  = 3'(k);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        chk("sweep_valid", out_valid, 1'b1);
        chk("sweep_out", out, sweep_exp[k-1]);
      end
    end
    step();

    in_valid = 1'b1;
    in1 = 32'h1234_5678;
    in2 = 32'h1234_5678;
    op  = 3'd2;
    step();
    in1 = 32'h1;
    op  = 3'd6;
    step();
    in_valid = 1'b0;
    chk("xor0_out", out, 32'h0);
    chk("xor0_zero", zero, 1'b1);
    chk("xor0_parity", parity, 1'b0);
    step();
    chk("pass1_out", out, 32'h1);
    chk("pass1_zero", zero, 1'b0);
    chk("pass1_parity", parity, 1'b1);
    step();

    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = (acc < 3);
      in1 = 32'h100 + 32'(acc);
      in2 = 32'h0F0;
      op  = 3'(acc + 1);
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, S);
    chk("bp_in_ready", in_ready, 1'b0);
    held = out;
    step();
    step();
    chk("bp_out_hold", out, held);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("bp_drained", q.size(), 0);
    chk("bp_out_valid", out_valid, 1'b0);

    cyc = 0;
    while (n_push < 1000 + 13 && cyc < 6000) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      in1       = $urandom;
      in2       = $urandom;
      op        = 3'($urandom_range(0, 7));
      out_ready = $urandom_range(0, 1) == 1;
      step();
      cyc++;
    end
    chk("rand_budget", (cyc < 6000), 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rand_drained", q.size(), 0);
    chk("push_pop_eq", n_pop, n_push);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in1 = 32'hDEAD_BEEF;
    in2 = 32'h1;
    op  = 3'd1;
    step();
    step();
    in_valid = 1'b0;
    chk("mid_full", in_ready, 1'b0);
    reset_n = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_out", out, 32'h0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_stale", out_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
